// File: rtl/branch_resolver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// branch_resolver : EX-stage prediction check, predictor update and redirect.
// Optional perf counters via BRANCH_RESOLVER_PERF_EN.      Rev 1.0
// ---------------------------------------------------------------------------
module branch_resolver #(
  parameter int DEPTH     = 4,
  parameter int FLUSH_CYC = 2,
  parameter int IDX_W     = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fetch_valid,
  output logic                fetch_ready,
  input  logic [31:0]         fetch_pc,
  input  logic [31:0]         fetch_pred_pc,
  input  logic                fetch_taken,
  input  logic                ex_valid,
  input  logic                ex_is_bj,
  input  logic [31:0]         ex_actual_pc,
  output logic                bp_update,
  output logic [IDX_W-1:0]    bp_idx,
  output logic [29-IDX_W:0]   bp_tag,
  output logic [31:0]         bp_target,
  output logic [31:0]         bp_pred_pc,
  output logic                bp_correct,
  output logic                bp_correct2,
  output logic                redirect_valid,
  output logic [31:0]         redirect_pc,
  output logic                flush,
  output logic                q_underflow,
  output logic [31:0]         bj_count,
  output logic [31:0]         mispred_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [CW-1:0] C_FLUSH_LAST = CW'(FLUSH_CYC - 1);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

  state_t              r_state, w_state_nxt;
  logic [CW-1:0]       r_fcnt;
  logic [PW-1:0]       r_wr, r_rd;
  logic [31:0]         r_q_pc   [DEPTH];
  logic [31:0]         r_q_pred [DEPTH];
  logic                r_q_taken[DEPTH];

  logic                r_upd, r_c, r_c2, r_rv, r_udf;
  logic [31:0]         r_pc, r_tgt, r_pp, r_rpc;

  logic                w_run, w_empty, w_full, w_push, w_pop, w_udf;
  logic [AW-1:0]       w_rd_idx;
  logic [31:0]         w_e_pc, w_e_pred;
  logic                w_e_taken, w_correct, w_correct2, w_mispred;

  assign w_run      = (r_state == ST_RUN);
  assign w_empty    = (r_wr == r_rd);
  assign w_full     = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign fetch_ready = reset && w_run && !w_full;
  assign w_push     = fetch_valid && fetch_ready;
  assign w_pop      = ex_valid && w_run && !w_empty;
  assign w_udf      = ex_valid && w_run && w_empty;

  assign w_rd_idx   = r_rd[AW-1:0];
  assign w_e_pc     = r_q_pc[w_rd_idx];
  assign w_e_pred   = r_q_pred[w_rd_idx];
  assign w_e_taken  = r_q_taken[w_rd_idx];
  assign w_correct  = (w_e_taken == (ex_actual_pc != (w_e_pc + 32'd4)));
  assign w_correct2 = (w_e_pred == ex_actual_pc);
  assign w_mispred  = w_pop && !w_correct2;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (w_mispred) w_state_nxt = ST_FLUSH;
      ST_FLUSH: if (r_fcnt == '0) w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_RUN;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_mispred)
        r_fcnt <= C_FLUSH_LAST;
      else if (r_state == ST_FLUSH && r_fcnt != '0)
        r_fcnt <= r_fcnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_wr[AW-1:0]]    <= fetch_pc;
      r_q_pred[r_wr[AW-1:0]]  <= fetch_pred_pc;
      r_q_taken[r_wr[AW-1:0]] <= fetch_taken;
    end
  end

  // A mispredict empties the queue; any same-cycle push is wrong-path and dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr <= '0;
      r_rd <= '0;
    end else if (w_mispred) begin
      r_rd <= r_wr;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_upd <= 1'b0;
      r_rv  <= 1'b0;
      r_c   <= 1'b0;
      r_c2  <= 1'b0;
      r_udf <= 1'b0;
      r_pc  <= '0;
      r_tgt <= '0;
      r_pp  <= '0;
      r_rpc <= '0;
    end else begin
      r_upd <= w_pop && ex_is_bj;
      r_rv  <= w_mispred;
      if (w_udf) r_udf <= 1'b1;
      if (w_pop) begin
        r_pc  <= w_e_pc;
        r_tgt <= ex_actual_pc;
        r_pp  <= w_e_pred;
        r_c   <= w_correct;
        r_c2  <= w_correct2;
      end
      if (w_mispred) r_rpc <= ex_actual_pc;
    end
  end

  assign bp_update      = r_upd;
  assign bp_idx         = r_pc[IDX_W+1:2];
  assign bp_tag         = r_pc[31:IDX_W+2];
  assign bp_target      = r_tgt;
  assign bp_pred_pc     = r_pp;
  assign bp_correct     = r_c;
  assign bp_correct2    = r_c2;
  assign redirect_valid = r_rv;
  assign redirect_pc    = r_rpc;
  assign flush          = (r_state == ST_FLUSH);
  assign q_underflow    = r_udf;

`ifdef BRANCH_RESOLVER_PERF_EN
  logic [31:0] r_bj_cnt, r_mis_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_bj_cnt  <= '0;
      r_mis_cnt <= '0;
    end else begin
      if (w_pop && ex_is_bj) r_bj_cnt  <= r_bj_cnt + 32'd1;
      if (w_mispred)         r_mis_cnt <= r_mis_cnt + 32'd1;
    end
  end

  assign bj_count      = r_bj_cnt;
  assign mispred_count = r_mis_cnt;
`else
  assign bj_count      = '0;
  assign mispred_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolver.sv
`default_nettype none
// tb_branch_resolver : directed + randomized bench against a queue-based model.
module tb_branch_resolver;
  localparam int DEPTH     = 4;
  localparam int FLUSH_CYC = 2;
  localparam int IDX_W     = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic fetch_valid = 1'b0, fetch_ready, fetch_taken = 1'b0;
  logic [31:0] fetch_pc = '0, fetch_pred_pc = '0;
  logic ex_valid = 1'b0, ex_is_bj = 1'b0;
  logic [31:0] ex_actual_pc = '0;
  logic bp_update, bp_correct, bp_correct2, redirect_valid, flush, q_underflow;
  logic [IDX_W-1:0] bp_idx;
  logic [29-IDX_W:0] bp_tag;
  logic [31:0] bp_target, bp_pred_pc, redirect_pc, bj_count, mispred_count;

  always #5 clk = ~clk;

  branch_resolver #(.DEPTH(DEPTH), .FLUSH_CYC(FLUSH_CYC), .IDX_W(IDX_W)) u_dut (
    .clk(clk), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
    .fetch_pred_pc(fetch_pred_pc), .fetch_taken(fetch_taken),
    .ex_valid(ex_valid), .ex_is_bj(ex_is_bj), .ex_actual_pc(ex_actual_pc),
    .bp_update(bp_update), .bp_idx(bp_idx), .bp_tag(bp_tag), .bp_target(bp_target),
    .bp_pred_pc(bp_pred_pc), .bp_correct(bp_correct), .bp_correct2(bp_correct2),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .q_underflow(q_underflow), .bj_count(bj_count), .mispred_count(mispred_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pred;
    logic        tk;
  } ent_t;

  ent_t        mq[$];
  int          flush_rem = 0;
  bit          m_udf = 0;
  logic [31:0] m_bj = '0, m_mis = '0;
  logic        e_upd = 0, e_c = 0, e_c2 = 0, e_rv = 0;
  logic [31:0] e_pc = '0, e_tgt = '0, e_pp = '0, e_rpc = '0;

  // One clock: apply inputs, predict the edge outcome from the model, compare.
  task automatic step(input bit rst_n, input bit fv, input logic [31:0] pc,
                      input logic [31:0] pred, input bit tk, input bit ev,
                      input bit bj, input logic [31:0] act);
    bit   exp_rdy, push;
    ent_t e;
    @(negedge clk);
    reset = rst_n; fetch_valid = fv; fetch_pc = pc; fetch_pred_pc = pred;
    fetch_taken = tk; ex_valid = ev; ex_is_bj = bj; ex_actual_pc = act;
    #1;
    exp_rdy = rst_n && (flush_rem == 0) && (mq.size() < DEPTH);
    check("fetch_ready", fetch_ready, exp_rdy);
    e_upd = 0;
    e_rv  = 0;
    if (!rst_n) begin
      mq.delete();
      flush_rem = 0; m_udf = 0; m_bj = '0; m_mis = '0;
      e_c = 0; e_c2 = 0; e_pc = '0; e_tgt = '0; e_pp = '0; e_rpc = '0;
    end else if (flush_rem > 0) begin
      flush_rem--;
    end else begin
      push = fv && exp_rdy;
      if (ev && mq.size() == 0) begin
        m_udf = 1;
      end else if (ev) begin
        e = mq.pop_front();
        e_upd = bj;
        e_pc = e.pc; e_tgt = act; e_pp = e.pred;
        e_c  = (e.tk == (act != e.pc + 32'd4));
        e_c2 = (e.pred == act);
        if (bj) m_bj = m_bj + 1;
        if (!e_c2) begin
          e_rv = 1; e_rpc = act; m_mis = m_mis + 1;
          flush_rem = FLUSH_CYC;
          mq.delete();
          push = 0;
        end
      end
      if (push) mq.push_back('{pc: pc, pred: pred, tk: tk});
    end
    @(posedge clk);
    #1;
    check("flush", flush, flush_rem > 0);
    check("q_underflow", q_underflow, m_udf);
    check("bp_update", bp_update, e_upd);
    check("bp_idx", bp_idx, e_pc[IDX_W+1:2]);
    check("bp_tag", bp_tag, e_pc[31:IDX_W+2]);
    check("bp_target", bp_target, e_tgt);
    check("bp_pred_pc", bp_pred_pc, e_pp);
    check("bp_correct", bp_correct, e_c);
    check("bp_correct2", bp_correct2, e_c2);
    check("redirect_valid", redirect_valid, e_rv);
    if (e_rv || !rst_n) check("redirect_pc", redirect_pc, e_rpc);
`ifdef BRANCH_RESOLVER_PERF_EN
    check("bj_count", bj_count, m_bj);
    check("mispred_count", mispred_count, m_mis);
`else
    check("bj_count", bj_count, 32'd0);
    check("mispred_count", mispred_count, 32'd0);
`endif
  endtask

  task automatic push_only(input logic [31:0] pc, input logic [31:0] pred, input bit tk);
    step(1, 1, pc, pred, tk, 0, 0, 32'h0);
  endtask

  task automatic resolve(input bit bj, input logic [31:0] act);
    step(1, 0, 32'h0, 32'h0, 0, 1, bj, act);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0);
  endtask

  task automatic rand_step();
    logic [31:0] pc, pred, act;
    bit tk;
    int r;
    pc = $urandom & 32'hFFFF_FFFC;
    r  = $urandom_range(0, 2);
    if (r == 0) begin pred = pc + 32'd4; tk = 0; end
    else if (r == 1) begin pred = $urandom & 32'hFFFF_FFFC; tk = 1; end
    else begin pred = $urandom & 32'hFFFF_FFFC; tk = 1'($urandom_range(0, 1)); end
    act = $urandom & 32'hFFFF_FFFC;
    if (mq.size() > 0) begin
      r = $urandom_range(0, 9);
      if (r < 7) act = mq[0].pred;
      else if (r < 9) act = mq[0].pc + 32'd4;
    end
    step(1, $urandom_range(0, 2) != 0, pc, pred, tk, $urandom_range(0, 3) != 0,
         $urandom_range(0, 3) != 0, act);
  endtask

  initial begin
    // Reset held two cycles with fetch_valid asserted
    step(0, 1, 32'h100, 32'h104, 0, 0, 0, 32'h0);
    step(0, 1, 32'h100, 32'h104, 0, 1, 1, 32'h0);
    idle(1);

    // Correct not-taken branch
    push_only(32'h100, 32'h104, 0);
    resolve(1, 32'h104);
    idle(1);

    // Full mispredict: flush for FLUSH_CYC cycles, queue emptied
    push_only(32'h40, 32'h44, 0);
    push_only(32'h48, 32'h4C, 0);
    resolve(1, 32'h80);
    idle(FLUSH_CYC + 1);

    // Target-only miss
    push_only(32'h200, 32'h300, 1);
    resolve(1, 32'h280);
    idle(FLUSH_CYC + 1);

    // Fill, back-pressure, pop+push at full, drain in order
    for (int i = 0; i < DEPTH; i++) push_only(32'h1000 + 32'(i * 4), 32'h1004 + 32'(i * 4), 0);
    push_only(32'h2000, 32'h2004, 0);
    step(1, 1, 32'h3000, 32'h3004, 0, 1, 1, 32'h1004);
    for (int i = 1; i < DEPTH; i++) resolve(1, 32'h1004 + 32'(i * 4));
    resolve(0, 32'h3004);

    // Underflow is sticky and produces no update
    resolve(1, 32'h500);
    idle(2);

    // Wraparound PC and a non-branch alias mispredict
    push_only(32'hFFFF_FFFC, 32'h0, 0);
    resolve(1, 32'h0);
    push_only(32'h600, 32'h604, 0);
    resolve(0, 32'h700);
    idle(FLUSH_CYC + 1);

    // Reset during flush aborts it
    push_only(32'h800, 32'h804, 0);
    resolve(1, 32'h900);
    step(0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0);
    idle(2);

    for (int i = 0; i < 3000; i++) rand_step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
